// File: rtl/bram_fifo_ctrl.sv
// FIFO controller driving an external true dual-port BRAM: port A writes, port B reads
// into a 2-entry out/skid stage that presents a first-word-fall-through stream.
module bram_fifo_ctrl #(
  parameter int RAM_WIDTH     = 16,
  parameter int RAM_ADDR_BITS = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [RAM_WIDTH-1:0]       s_data_i,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  output logic [RAM_WIDTH-1:0]       m_data_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [RAM_ADDR_BITS+1:0]   count_o,
  output logic [RAM_ADDR_BITS-1:0]   ram_addr_a_o,
  output logic [RAM_WIDTH-1:0]       ram_data_a_o,
  output logic                       ram_we_a_o,
  output logic                       ram_en_a_o,
  output logic [RAM_ADDR_BITS-1:0]   ram_addr_b_o,
  output logic                       ram_en_b_o,
  input  logic [RAM_WIDTH-1:0]       ram_data_b_i
);
  localparam int RAM_DEPTH = 2**RAM_ADDR_BITS;
  localparam int CW        = RAM_ADDR_BITS + 2;

  logic [RAM_ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [RAM_ADDR_BITS:0]   ram_cnt, ram_cnt_nxt;
  logic                     out_v, skid_v, rd_pend;
  logic                     out_v_nxt, skid_v_nxt;
  logic [RAM_WIDTH-1:0]     skid_data;
  logic                     push, pop;
  logic [2:0]               occ;

  assign push = s_valid_i & s_ready_o;
  assign pop  = out_v & m_ready_i;

  assign ram_en_a_o   = push;
  assign ram_we_a_o   = push;
  assign ram_addr_a_o = wr_ptr;
  assign ram_data_a_o = s_data_i;

  // Only issue a read if the stage will have room for it once it returns;
  // compare against 2+pop to avoid underflow in the subtraction.
  assign occ          = 3'(out_v) + 3'(skid_v) + 3'(rd_pend);
  assign ram_en_b_o   = (ram_cnt != '0) && (occ < (3'd2 + 3'(pop)));
  assign ram_addr_b_o = rd_ptr;

  assign m_valid_o = out_v;

  always_comb begin
    ram_cnt_nxt = ram_cnt;
    if (push && !ram_en_b_o)      ram_cnt_nxt = ram_cnt + 1'b1;
    else if (!push && ram_en_b_o) ram_cnt_nxt = ram_cnt - 1'b1;
  end

  always_comb begin
    out_v_nxt  = out_v;
    skid_v_nxt = skid_v;
    if (pop) begin
      if (skid_v) skid_v_nxt = rd_pend;
      else        out_v_nxt  = rd_pend;
    end else if (!out_v && rd_pend) begin
      out_v_nxt = 1'b1;
    end else if (rd_pend) begin
      skid_v_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      out_v     <= 1'b0;
      skid_v    <= 1'b0;
      rd_pend   <= 1'b0;
      m_data_o  <= '0;
      skid_data <= '0;
      count_o   <= '0;
      s_ready_o <= 1'b0;
    end else begin
      if (push)       wr_ptr <= wr_ptr + 1'b1;
      if (ram_en_b_o) rd_ptr <= rd_ptr + 1'b1;
      ram_cnt   <= ram_cnt_nxt;
      rd_pend   <= ram_en_b_o;
      out_v     <= out_v_nxt;
      skid_v    <= skid_v_nxt;
      s_ready_o <= (ram_cnt_nxt < (RAM_ADDR_BITS+1)'(RAM_DEPTH));
      count_o   <= CW'(ram_cnt_nxt) + CW'(out_v_nxt) + CW'(skid_v_nxt) + CW'(ram_en_b_o);
      // Data moves mirror the valid updates above.
      if (pop) begin
        if (skid_v) begin
          m_data_o <= skid_data;
          if (rd_pend) skid_data <= ram_data_b_i;
        end else if (rd_pend) begin
          m_data_o <= ram_data_b_i;
        end
      end else if (!out_v && rd_pend) begin
        m_data_o <= ram_data_b_i;
      end else if (rd_pend) begin
        skid_data <= ram_data_b_i;
      end
    end
  end
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: behavioural BRAM, scoreboard monitor, one task per scenario.
module tb_bram_fifo_ctrl;
  localparam int W  = 16;
  localparam int AB = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [AB+1:0] count;
  logic [AB-1:0] addr_a, addr_b;
  logic [W-1:0]  data_a;
  logic          we_a, en_a, en_b;
  logic [W-1:0]  data_b = '0;
  logic [W-1:0]  mem [2**AB];

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int wr_wraps = 0;
  int rd_wraps = 0;
  logic [W-1:0] q [$];

  always #5 clk = ~clk;

  bram_fifo_ctrl #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .count_o(count),
    .ram_addr_a_o(addr_a), .ram_data_a_o(data_a), .ram_we_a_o(we_a), .ram_en_a_o(en_a),
    .ram_addr_b_o(addr_b), .ram_en_b_o(en_b), .ram_data_b_i(data_b)
  );

  // Behavioural BRAM with one-cycle read latency on port B.
  always @(posedge clk) begin
    if (en_a && we_a) mem[addr_a] <= data_a;
    if (en_b) data_b <= mem[addr_b];
  end

  // Scoreboard monitor: expected words enqueued on accept, compared on pop.
  always @(negedge clk) begin
    logic [W-1:0] exp;
    if (rst) q.delete();
    else begin
      if (m_valid && m_ready) begin
        checks++;
        pops++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_pop_unexpected got %h expected none", m_data);
        end else begin
          exp = q.pop_front();
          if (m_data !== exp) begin
            errors++;
            $display("FAIL sb_data got %h expected %h", m_data, exp);
          end
        end
      end
      if (s_valid && s_ready) q.push_back(s_data);
      if (we_a && addr_a == 3'd7) wr_wraps++;
      if (en_b && addr_b == 3'd7) rd_wraps++;
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b expected 0", m_valid); end
    checks++; if (count !== '0) begin errors++; $display("FAIL rst_count got %0d expected 0", count); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got %b expected 0", s_ready); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready_early got %b expected 0", s_ready); end
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready_rise got %b expected 1", s_ready); end
    next_cycle();
  endtask

  task automatic test_latency();
    s_valid = 1'b1; s_data = 16'h1234; m_ready = 1'b1;
    @(negedge clk);
    next_cycle();
    s_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c < 3) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid cyc %0d got %b expected 0", c, m_valid); end
      end else begin
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h1234) begin
          errors++; $display("FAIL lat_cycle3 got v=%b d=%h expected v=1 d=1234", m_valid, m_data); end
      end
      next_cycle();
    end
    checks++; if (count !== '0) begin errors++; $display("FAIL lat_count got %0d expected 0", count); end
    m_ready = 1'b0;
  endtask

  task automatic test_fill();
    int acc = 0;
    int w = 1;
    m_ready = 1'b0;
    for (int c = 0; c < 20 && w <= 12; c++) begin
      s_valid = 1'b1; s_data = 16'(w);
      @(negedge clk);
      if (s_ready) begin acc++; w++; end
      next_cycle();
    end
    s_valid = 1'b0;
    @(negedge clk);
    checks++; if (acc != 10) begin errors++; $display("FAIL fill_accepted got %0d expected 10", acc); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_s_ready got %b expected 0", s_ready); end
    checks++; if (count !== 5'd10) begin errors++; $display("FAIL fill_count got %0d expected 10", count); end
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h0001) begin
      errors++; $display("FAIL fill_head got v=%b d=%h expected v=1 d=0001", m_valid, m_data); end
    next_cycle();
  endtask

  task automatic test_drain();
    m_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL drain_gap cyc %0d got v=%b expected 1", k, m_valid); end
      if (k == 0) begin
        checks++; if (en_b !== 1'b1) begin errors++; $display("FAIL drain_first_read got %b expected 1", en_b); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL drain_s_ready_c0 got %b expected 0", s_ready); end
      end
      if (k == 1) begin
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL drain_s_ready_c1 got %b expected 1", s_ready); end
      end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (m_valid !== 1'b0 || count !== '0) begin
      errors++; $display("FAIL drain_empty got v=%b cnt=%0d expected v=0 cnt=0", m_valid, count); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL drain_sb_left got %0d expected 0", q.size()); end
    next_cycle();
    m_ready = 1'b0;
  endtask

  task automatic test_random();
    int sent = 0;
    int p0 = pops;
    wr_wraps = 0; rd_wraps = 0;
    for (int c = 0; c < 5000 && sent < 200; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 16'($urandom);
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s_valid && s_ready) sent++;
      next_cycle();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < 100 && (q.size() != 0 || count != 0); c++) next_cycle();
    m_ready = 1'b0;
    checks++; if (sent != 200) begin errors++; $display("FAIL rnd_sent got %0d expected 200", sent); end
    checks++; if (pops - p0 != 200) begin errors++; $display("FAIL rnd_popped got %0d expected 200", pops - p0); end
    checks++; if (q.size() != 0 || count !== '0) begin
      errors++; $display("FAIL rnd_residue got q=%0d cnt=%0d expected 0 0", q.size(), count); end
    checks++; if (wr_wraps < 20 || rd_wraps < 20) begin
      errors++; $display("FAIL rnd_wraps got wr=%0d rd=%0d expected >=20", wr_wraps, rd_wraps); end
  endtask

  task automatic test_hold();
    int waited = 0;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 16'hA5A5;
    next_cycle();
    s_valid = 1'b0;
    while (!m_valid && waited < 10) begin next_cycle(); waited++; end
    checks++; if (!m_valid) begin errors++; $display("FAIL hold_timeout got v=0 expected 1"); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (m_valid !== 1'b1 || m_data !== 16'hA5A5) begin
        errors++; $display("FAIL hold_stable cyc %0d got v=%b d=%h expected v=1 d=a5a5", k, m_valid, m_data); end
      next_cycle();
    end
    m_ready = 1'b1;
    next_cycle();
    m_ready = 1'b0;
    @(negedge clk);
    checks++; if (q.size() != 0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL hold_pop got q=%0d v=%b expected 0 0", q.size(), m_valid); end
    next_cycle();
  endtask

  task automatic test_async_reset();
    int waited = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1; s_data = 16'(16'h0100 + i);
      next_cycle();
    end
    s_data = 16'h0107; m_ready = 1'b1;
    next_cycle();
    s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    checks++; if (count !== 5'd6 || dut.rd_pend !== 1'b1) begin
      errors++; $display("FAIL ar_precond got cnt=%0d rd_pend=%b expected 6 1", count, dut.rd_pend); end
    #1 rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0 || count !== '0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL ar_immediate got v=%b cnt=%0d rdy=%b expected 0 0 0", m_valid, count, s_ready); end
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle();
    s_valid = 1'b1; s_data = 16'hBEEF; m_ready = 1'b1;
    while (!s_ready && waited < 10) begin next_cycle(); waited++; end
    next_cycle();
    s_valid = 1'b0;
    waited = 0;
    while (!m_valid && waited < 10) begin next_cycle(); waited++; end
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || m_data !== 16'hBEEF) begin
      errors++; $display("FAIL ar_first_word got v=%b d=%h expected v=1 d=beef", m_valid, m_data); end
    next_cycle();
    m_ready = 1'b0;
    @(negedge clk);
    checks++; if (count !== '0 || q.size() != 0) begin
      errors++; $display("FAIL ar_final got cnt=%0d q=%0d expected 0 0", count, q.size()); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_drain();
    test_random();
    test_hold();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
Single-clock FIFO controller that uses an external true dual-port BRAM as storage. Port A is write-only and fed from an upstream valid/ready stream. Port B is read-only and drains into a 2-entry registered output stage, giving a first-word-fall-through valid/ready stream downstream. The stage sits directly in front of the team's bram_dp_true_2clk and owns all of its address, enable and write-enable signals, with clk_a_i and clk_b_i both tied to clk_i.

Parameters:
RAM_WIDTH, 16, data word width; must match the BRAM.
RAM_ADDR_BITS, 3, BRAM address width. RAM_DEPTH = 2**RAM_ADDR_BITS is derived as a localparam.

Ports:
clk_i  in  1  clock for all logic; BRAM clocks are tied to it.
rst_i  in  1  asynchronous, active-high reset.
s_data_i  in  RAM_WIDTH  upstream write data.
s_valid_i  in  1  upstream data valid.
s_ready_o  out  1  FIFO can accept a word.
m_data_o  out  RAM_WIDTH  head-of-FIFO data, registered.
m_valid_o  out  1  m_data_o holds a valid word.
m_ready_i  in  1  downstream accepts the word.
count_o  out  RAM_ADDR_BITS+2  total words held: RAM + output stage + read in flight.
ram_addr_a_o  out  RAM_ADDR_BITS  BRAM port A address (write pointer).
ram_data_a_o  out  RAM_WIDTH  BRAM port A write data.
ram_we_a_o  out  1  BRAM port A write enable.
ram_en_a_o  out  1  BRAM port A enable.
ram_addr_b_o  out  RAM_ADDR_BITS  BRAM port B address (read pointer).
ram_en_b_o  out  1  BRAM port B enable (read request).
ram_data_b_i  in  RAM_WIDTH  BRAM port B read data; valid one cycle after ram_en_b_o is sampled.

Behaviour:
- Reset (rst_i=1, acts immediately) sets wr_ptr, rd_ptr, ram_cnt, out_v, skid_v, rd_pend, m_valid_o, m_data_o, count_o and s_ready_o to 0.
- s_ready_o is a registered not-full flag, (ram_cnt < RAM_DEPTH). It rises on the first clk_i edge after rst_i deasserts.
- Write: push = s_valid_i & s_ready_o.
  - ram_en_a_o = ram_we_a_o = push (combinational).
  - ram_addr_a_o = wr_ptr; ram_data_a_o = s_data_i.
  - wr_ptr increments on push and wraps RAM_DEPTH-1 -> 0.
- Read issue:
  - pop = m_valid_o & m_ready_i.
  - ram_en_b_o = (ram_cnt != 0) & ((out_v + skid_v + rd_pend - pop) < 2), combinational.
  - ram_addr_b_o = rd_ptr; rd_ptr wraps RAM_DEPTH-1 -> 0.
  - rd_pend <= ram_en_b_o.
  - Because a read requires ram_cnt != 0 (count as of the previous edge), a read and a write never target the same address in the same cycle.
- ram_cnt: +1 on push, -1 on ram_en_b_o; both in the same cycle leaves it unchanged.
- Output stage: out register (m_data_o/out_v) plus skid register (skid_v). Per edge, in priority order:
  - If pop: out loads skid if skid_v; else out loads ram_data_b_i if rd_pend; else out_v goes to 0.
  - If out is empty (or becoming empty) and rd_pend: out loads ram_data_b_i.
  - Otherwise, if rd_pend: skid loads ram_data_b_i.
  - The issue rule guarantees returning data is never dropped.
- m_valid_o = out_v. m_data_o is held stable while m_valid_o & ~m_ready_i.
- Latency from empty:
  - Word accepted in cycle 0 -> ram_en_b_o in cycle 1 -> ram_data_b_i in cycle 2 -> m_valid_o=1 in cycle 3.
  - Steady-state throughput is 1 word/cycle in each direction.
- Capacity is RAM_DEPTH+2 words: RAM_DEPTH in RAM plus 2 in the output stage. count_o = ram_cnt + out_v + skid_v + rd_pend, registered.
- Reset mid-operation: all contents are discarded. A read in flight is abandoned; ram_data_b_i in the cycle after reset is ignored.
- Order is strictly preserved across pointer wrap. No overflow or underflow is possible through the ports.

Test Plan:
1. Reset, then push 0x1234 in cycle 0 with m_ready_i=1 -> m_valid_o=1 with m_data_o=0x1234 in cycle 3; popped that cycle; count_o returns to 0.
2. m_ready_i=0, push 0x0001..0x000C back-to-back -> exactly 10 words accepted; s_ready_o=0 after the 10th; count_o=10; m_data_o=0x0001 stable.
3. From the full state of scenario 2, set m_ready_i=1 -> 0x0001..0x000A out one per cycle with no gaps; s_ready_o returns to 1 one cycle after the first RAM read issues.
4. 200 random words with random s_valid_i/m_ready_i (50%) -> output sequence equals input sequence; wr_ptr and rd_ptr wrap at least 20 times.
5. With m_valid_o=1, hold m_ready_i=0 for 5 cycles -> m_data_o and m_valid_o unchanged; the next pop yields the same word.
6. Assert rst_i asynchronously while rd_pend=1 and count_o=6 -> m_valid_o, count_o and s_ready_o are 0 without a clock edge. After release, the next pushed word 0xBEEF is the first word out.
